// File: rtl/excess3_conv_arbiter_if.sv
// Request/result bundle for excess3_conv_arbiter: two BCD requesters in, one excess-3 result out.
interface excess3_conv_arbiter_if #(
  parameter int DW = 4,
  parameter int ND = 4
);
  logic [1:0]       req;
  logic [ND*DW-1:0] din0;
  logic [ND*DW-1:0] din1;
  logic [1:0]       gnt;
  logic             busy;
  logic [ND*DW-1:0] dout;
  logic             dout_id;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_err;

  modport master (
    output req, din0, din1, dout_ready,
    input  gnt, busy, dout, dout_id, dout_valid, dout_err
  );

  modport slave (
    input  req, din0, din1, dout_ready,
    output gnt, busy, dout, dout_id, dout_valid, dout_err
  );
endinterface

// File: rtl/excess3_conv_arbiter.sv
// Round-robin shared BCD->excess-3 converter, one digit per cycle, LSD first.
// Optional invalid-digit flag enabled by defining E3_BCD_ERRCHK_EN.
module excess3_conv_arbiter #(
  parameter int DW = 4,
  parameter int ND = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  excess3_conv_arbiter_if.slave  bus
);

  localparam int WW = ND * DW;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_last;
  logic           r_id;
  logic           r_dout_id;
  logic [CW-1:0]  r_cnt;
  logic [WW-1:0]  r_din;
  logic [WW-1:0]  r_acc;
  logic [WW-1:0]  r_dout;

  logic           w_accept;
  logic           w_pick;
  logic           w_last_digit;
  logic [DW-1:0]  w_digit;
  logic [DW-1:0]  w_conv;
  logic [WW-1:0]  w_acc_next;

  assign w_accept     = (r_state == S_IDLE) && (bus.req != 2'b00);
  // With both requesting, take the one not served last; otherwise the lone requester.
  assign w_pick       = (bus.req == 2'b11) ? ~r_last : bus.req[1];
  assign w_digit      = r_din[r_cnt*DW +: DW];
  assign w_conv       = w_digit + DW'(3);
  assign w_last_digit = (r_cnt == CW'(ND - 1));

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[r_cnt*DW +: DW] = w_conv;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CONV;
      S_CONV:  if (w_last_digit) w_next = S_DONE;
      S_DONE:  if (bus.dout_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last    <= 1'b1;
      r_id      <= 1'b0;
      r_cnt     <= '0;
      r_din     <= '0;
      r_acc     <= '0;
      r_dout    <= '0;
      r_dout_id <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last <= w_pick;
        r_id   <= w_pick;
        r_din  <= w_pick ? bus.din1 : bus.din0;
        r_cnt  <= '0;
        r_acc  <= '0;
      end
      if (r_state == S_CONV) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 1'b1;
        // dout only moves here, so partial words never appear on it.
        if (w_last_digit) begin
          r_dout    <= w_acc_next;
          r_dout_id <= r_id;
        end
      end
    end
  end

  always_comb begin
    bus.gnt        = '0;
    bus.busy       = 1'b0;
    bus.dout_valid = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept && !rst) bus.gnt[w_pick] = 1'b1;
      S_CONV: bus.busy = 1'b1;
      S_DONE: begin
        bus.busy       = 1'b1;
        bus.dout_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.dout    = r_dout;
  assign bus.dout_id = r_dout_id;

`ifdef E3_BCD_ERRCHK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst)                                        r_err <= 1'b0;
    else if (w_accept)                              r_err <= 1'b0;
    else if (r_state == S_CONV && w_digit > DW'(9)) r_err <= 1'b1;
  end

  assign bus.dout_err = r_err & (r_state == S_DONE);
`else
  assign bus.dout_err = 1'b0;
`endif

endmodule
